// File: rtl/xnor_cmp_pkg.sv
// rtl/xnor_cmp_pkg.sv - shared types and width helpers for the bit-serial compare scheduler
package xnor_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESP    = 2'd2
  } state_t;

  // Requester-ID width; never narrower than one bit
  function automatic int calc_idw(input int n_req);
    return ($clog2(n_req) < 1) ? 1 : $clog2(n_req);
  endfunction

  // Bit-index width; never narrower than one bit
  function automatic int calc_bw(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/xnor_cmp_scheduler_ex_nor_gate.sv
// rtl/xnor_cmp_scheduler_ex_nor_gate.sv - single 1-bit XNOR cell shared by all requesters
module EX_NOR_GATE (
  output logic Y,
  input  logic A,
  input  logic B
);

  // Y is high when the two operand bits agree
  assign Y = ~(A ^ B);

endmodule

// File: rtl/xnor_cmp_scheduler.sv
// rtl/xnor_cmp_scheduler.sv - round-robin bit-serial equality compare through one XNOR cell
module xnor_cmp_scheduler
  import xnor_cmp_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_REQ = 2,
  localparam int IDW   = calc_idw(N_REQ),
  localparam int BW    = calc_bw(WIDTH)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [N_REQ-1:0]       REQ_VALID,
  output logic [N_REQ-1:0]       REQ_READY,
  input  logic [N_REQ*WIDTH-1:0] REQ_A,
  input  logic [N_REQ*WIDTH-1:0] REQ_B,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic                   RSP_EQ,
  output logic [IDW-1:0]         RSP_ID,
  output logic [BW-1:0]          RSP_IDX,
  output logic                   BUSY
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [BW-1:0]    r_cnt;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_last;
  logic             r_rsp_valid;
  logic             r_rsp_eq;
  logic [BW-1:0]    r_rsp_idx;
  logic             r_busy;

  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_gid;
  logic             w_any;
  logic             w_bit_eq;
  logic             w_last_bit;

  // Round-robin pick: first valid requester starting just after the last one served
  always_comb begin
    logic [IDW-1:0] cand;
    w_grant = '0;
    w_gid   = '0;
    w_any   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(r_last) + k) % N_REQ);
      if (!w_any && REQ_VALID[cand]) begin
        w_grant[cand] = 1'b1;
        w_gid         = cand;
        w_any         = 1'b1;
      end
    end
  end

  // Grant is only offered while idle and out of reset, so it can never overlap a response
  assign REQ_READY = w_grant & {N_REQ{RST_N}} & {N_REQ{r_state == IDLE}};

  EX_NOR_GATE u_xnor (
    .Y (w_bit_eq),
    .A (r_a_sh[0]),
    .B (r_b_sh[0])
  );

  assign w_last_bit = (r_cnt == BW'(WIDTH - 1));

  // Control FSM: accept, walk bits LSB-first with early exit, hold response until taken
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_cnt       <= '0;
      r_id        <= '0;
      r_last      <= IDW'(N_REQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_eq    <= 1'b0;
      r_rsp_idx   <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a_sh  <= REQ_A[w_gid*WIDTH +: WIDTH];
            r_b_sh  <= REQ_B[w_gid*WIDTH +: WIDTH];
            r_id    <= w_gid;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (!w_bit_eq) begin
            r_rsp_eq    <= 1'b0;
            r_rsp_idx   <= r_cnt;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_last_bit) begin
            r_rsp_eq    <= 1'b1;
            r_rsp_idx   <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_cnt  <= r_cnt + BW'(1);
          end
        end
        RESP: begin
          if (RSP_READY) begin
            r_last      <= r_id;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign RSP_VALID = r_rsp_valid;
  assign RSP_EQ    = r_rsp_eq;
  assign RSP_ID    = r_id;
  assign RSP_IDX   = r_rsp_idx;
  assign BUSY      = r_busy;

endmodule
